// File: rtl/octa_pkg.sv
// ----------------------------------------------------------------------------
// octa_pkg
// Shared definitions for the Octa16 8-bit datapath execute stage.
//   - DEF_WIDTH / DEF_AW : default data and register-address widths
//   - op_t               : 4-bit opcode encodings OP_NOP..OP_MUL
//   - FLAG_*             : bit positions of Z/N/C inside the flag register
//   - make_flags()       : packs Z/N/C into the flag-register layout
// ----------------------------------------------------------------------------
package octa_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int NFLAGS = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_ADC = 4'h2,
    OP_SUB = 4'h3,
    OP_SBB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7,
    OP_NOT = 4'h8,
    OP_SHL = 4'h9,
    OP_SHR = 4'hA,
    OP_INC = 4'hB,
    OP_DEC = 4'hC,
    OP_MOV = 4'hD,
    OP_CMP = 4'hE,
    OP_MUL = 4'hF
  } op_t;

  // Pack individual flag values into the flag-register bit layout.
  function automatic logic [NFLAGS-1:0] make_flags(input logic z, input logic n, input logic c);
    logic [NFLAGS-1:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/exec_stage_if.sv
// ----------------------------------------------------------------------------
// exec_stage_if
// Bundle between the decode/register-file side and the execute stage.
//   master (upstream) drives : valid_in, op, rd_in, a, b
//   slave  (exec_stage) drives: busy, wr_en, rd, din, flag_z, flag_n, flag_c
// ----------------------------------------------------------------------------
interface exec_stage_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) ();

  logic             valid_in;
  logic [3:0]       op;
  logic [AW-1:0]    rd_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             wr_en;
  logic [AW-1:0]    rd;
  logic [WIDTH-1:0] din;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;

  modport master (
    output valid_in, op, rd_in, a, b,
    input  busy, wr_en, rd, din, flag_z, flag_n, flag_c
  );

  modport slave (
    input  valid_in, op, rd_in, a, b,
    output busy, wr_en, rd, din, flag_z, flag_n, flag_c
  );

endinterface

// File: rtl/exec_stage_mul_seq.sv
// ----------------------------------------------------------------------------
// mul_seq
// Sequential shift-add multiplier, one multiplier bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands; bit 0 is consumed on the start edge itself
//   a, b       : multiplicand, multiplier
//   done       : one-cycle pulse, high after the edge that retires bit WIDTH-1
//   prod       : 2*WIDTH-bit product, valid while done is high
// With WIDTH=8 and start at edge T, done/prod are valid after edge T+7.
// ----------------------------------------------------------------------------
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_it;
  logic               r_run;
  logic               r_done;

  // Operand load and per-cycle shift-add iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_it     <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        // Retire multiplier bit 0 immediately so the last bit lands one edge earlier.
        r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
        r_mplier <= {1'b0, b[WIDTH-1:1]};
        r_it     <= CW'(1);
        r_run    <= 1'b1;
      end else if (r_run) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end else begin
          r_acc <= r_acc;
        end
        r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        r_it     <= r_it + CW'(1);
        if (r_it == CW'(WIDTH-1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_run  <= 1'b1;
        end
      end else begin
        r_run <= 1'b0;
      end
    end
  end

  assign done = r_done;
  assign prod = r_acc;

endmodule

// File: rtl/exec_stage.sv
// ----------------------------------------------------------------------------
// exec_stage
// Execute stage of the Octa16 datapath: combinational 16-op ALU, Z/N/C flag
// register and registered register-file write port.
//   clk, rst_n : clock shared with reg_ff, asynchronous active-low reset
//   io (slave) : valid_in/op/rd_in/a/b in; busy/wr_en/rd/din/flag_* out
// Build option: EXEC_MUL_EN enables opcode F (MUL) through the mul_seq
// multiplier and an IDLE/MUL FSM; without it opcode F acts as NOP and busy=0.
// ----------------------------------------------------------------------------
module exec_stage
  import octa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input logic        clk,
  input logic        rst_n,
  exec_stage_if.slave io
);

  op_t              w_op;
  logic             w_accept;
  logic [WIDTH:0]   w_ext;
  logic             w_arith;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_wr;
  logic             w_upd;
  logic [WIDTH:0]   w_cin;
  logic [WIDTH:0]   w_one;

  logic              r_wr_en;
  logic [AW-1:0]     r_rd;
  logic [WIDTH-1:0]  r_din;
  logic [NFLAGS-1:0] r_flags;

  assign w_op  = op_t'(io.op);
  assign w_cin = {{WIDTH{1'b0}}, r_flags[FLAG_C]};
  assign w_one = {{WIDTH{1'b0}}, 1'b1};

`ifdef EXEC_MUL_EN
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t             r_state;
  logic [2:0]         r_cnt;
  logic               r_busy;
  logic [AW-1:0]      r_mul_rd;
  logic               w_is_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept = io.valid_in && !r_busy;
  assign w_is_mul = (w_op == OP_MUL);
  assign io.busy  = r_busy;

  mul_seq #(.WIDTH(WIDTH)) u_mul_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_accept && w_is_mul),
    .a     (io.a),
    .b     (io.b),
    .done  (w_mul_done),
    .prod  (w_prod)
  );
`else
  assign w_accept = io.valid_in;
  assign io.busy  = 1'b0;
`endif

  // Single-cycle ALU: result, carry/borrow, and whether to write / update flags.
  always_comb begin
    w_ext   = '0;
    w_arith = 1'b0;
    w_res   = '0;
    w_c     = 1'b0;
    w_wr    = 1'b1;
    w_upd   = 1'b1;
    case (w_op)
      OP_NOP: begin w_wr = 1'b0; w_upd = 1'b0; end
      OP_ADD: begin w_arith = 1'b1; w_ext = {1'b0, io.a} + {1'b0, io.b}; end
      OP_ADC: begin w_arith = 1'b1; w_ext = {1'b0, io.a} + {1'b0, io.b} + w_cin; end
      OP_SUB: begin w_arith = 1'b1; w_ext = {1'b0, io.a} - {1'b0, io.b}; end
      OP_SBB: begin w_arith = 1'b1; w_ext = {1'b0, io.a} - {1'b0, io.b} - w_cin; end
      OP_AND: begin w_res = io.a & io.b; end
      OP_OR:  begin w_res = io.a | io.b; end
      OP_XOR: begin w_res = io.a ^ io.b; end
      OP_NOT: begin w_res = ~io.a; end
      OP_SHL: begin w_res = {io.a[WIDTH-2:0], 1'b0}; w_c = io.a[WIDTH-1]; end
      OP_SHR: begin w_res = {1'b0, io.a[WIDTH-1:1]}; w_c = io.a[0]; end
      OP_INC: begin w_arith = 1'b1; w_ext = {1'b0, io.a} + w_one; end
      OP_DEC: begin w_arith = 1'b1; w_ext = {1'b0, io.a} - w_one; end
      OP_MOV: begin w_res = io.b; end
      OP_CMP: begin w_arith = 1'b1; w_ext = {1'b0, io.a} - {1'b0, io.b}; w_wr = 1'b0; end
      // MUL never completes here: the FSM handles it, or it degrades to NOP.
      OP_MUL: begin w_wr = 1'b0; w_upd = 1'b0; end
      default: begin w_wr = 1'b0; w_upd = 1'b0; end
    endcase
    // The extra top bit of a WIDTH+1 subtraction is the borrow, of an addition the carry.
    if (w_arith) begin
      w_res = w_ext[WIDTH-1:0];
      w_c   = w_ext[WIDTH];
    end else begin
      w_ext = w_ext;
    end
  end

  // Multiply FSM plus write-port and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= 1'b0;
      r_rd    <= '0;
      r_din   <= '0;
      r_flags <= '0;
`ifdef EXEC_MUL_EN
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_busy   <= 1'b0;
      r_mul_rd <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
`ifdef EXEC_MUL_EN
      if (r_state == ST_MUL) begin
        if (r_cnt == 3'd7) begin
          // mul_seq retires its last bit one edge earlier, so prod is settled here.
          r_state <= ST_IDLE;
          r_cnt   <= 3'd0;
          r_busy  <= 1'b0;
          r_wr_en <= w_mul_done;
          r_rd    <= r_mul_rd;
          r_din   <= w_prod[WIDTH-1:0];
          r_flags <= make_flags(w_prod[WIDTH-1:0] == '0, w_prod[WIDTH-1],
                                |w_prod[2*WIDTH-1:WIDTH]);
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end else if (w_accept && w_is_mul) begin
        r_state  <= ST_MUL;
        r_cnt    <= 3'd0;
        r_busy   <= 1'b1;
        r_mul_rd <= io.rd_in;
      end else
`endif
      if (w_accept) begin
        if (w_wr) begin
          r_wr_en <= 1'b1;
          r_rd    <= io.rd_in;
          r_din   <= w_res;
        end else begin
          r_wr_en <= 1'b0;
        end
        if (w_upd) begin
          r_flags <= make_flags(w_res == '0, w_res[WIDTH-1], w_c);
        end else begin
          r_flags <= r_flags;
        end
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign io.wr_en  = r_wr_en;
  assign io.rd     = r_rd;
  assign io.din    = r_din;
  assign io.flag_z = r_flags[FLAG_Z];
  assign io.flag_n = r_flags[FLAG_N];
  assign io.flag_c = r_flags[FLAG_C];

endmodule

// File: tb/tb_exec_stage.sv
// ----------------------------------------------------------------------------
// tb_exec_stage
// Directed self-checking bench for exec_stage. Each observation packs
// {busy, wr_en, rd[2:0], din[7:0], Z, N, C} into 16 bits and compares it
// against a hand-computed value.
// ----------------------------------------------------------------------------
module tb_exec_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exec_stage_if #(.WIDTH(8), .AW(3)) bus ();

  exec_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  wire [15:0] obs = {bus.busy, bus.wr_en, bus.rd, bus.din, bus.flag_z, bus.flag_n, bus.flag_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [7:0] a, input logic [7:0] b);
    bus.valid_in = v;
    bus.op       = op;
    bus.rd_in    = rd;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic test_reset();
    drive(1'b0, 4'h0, 3'd0, 8'h00, 8'h00);
    rst_n = 1'b0;
    #12;
    total++;
    if (obs !== 16'h0000) begin bad++; $display("FAIL reset got=%h exp=%h", obs, 16'h0000); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== 16'h0000) begin bad++; $display("FAIL reset_idle got=%h exp=%h", obs, 16'h0000); end
  endtask

  task automatic test_add();
    logic [15:0] exp;
    drive(1'b1, 4'h1, 3'd1, 8'hFF, 8'h01);
    @(posedge clk); #1;
    drive(1'b0, 4'h0, 3'd0, 8'h00, 8'h00);
    exp = {1'b0, 1'b1, 3'd1, 8'h00, 3'b101};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL add got=%h exp=%h", obs, exp); end
    @(posedge clk); #1;
    exp = {1'b0, 1'b0, 3'd1, 8'h00, 3'b101};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL add_pulse got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    drive(1'b1, 4'h3, 3'd2, 8'h03, 8'hAB);
    @(posedge clk); #1;
    exp = {1'b0, 1'b1, 3'd2, 8'h58, 3'b001};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL sub got=%h exp=%h", obs, exp); end
    drive(1'b1, 4'h4, 3'd3, 8'h10, 8'h00);
    @(posedge clk); #1;
    exp = {1'b0, 1'b1, 3'd3, 8'h0F, 3'b000};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL sbb got=%h exp=%h", obs, exp); end
    drive(1'b1, 4'hE, 3'd4, 8'h5A, 8'h5A);
    @(posedge clk); #1;
    drive(1'b0, 4'h0, 3'd0, 8'h00, 8'h00);
    exp = {1'b0, 1'b0, 3'd3, 8'h0F, 3'b100};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL cmp got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  t_op  [10] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'h2, 4'hC, 4'hD};
    logic [7:0]  t_a   [10] = '{8'hF0, 8'hF0, 8'hA5, 8'h0F, 8'h81, 8'h81, 8'hFF, 8'h01, 8'h00, 8'h11};
    logic [7:0]  t_b   [10] = '{8'h3C, 8'h0C, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h80};
    logic [7:0]  t_d   [10] = '{8'h30, 8'hFC, 8'h00, 8'hF0, 8'h02, 8'h40, 8'h00, 8'h03, 8'hFF, 8'h80};
    logic [2:0]  t_f   [10] = '{3'b000, 3'b010, 3'b100, 3'b010, 3'b001, 3'b001, 3'b101, 3'b000, 3'b011, 3'b010};
    logic [15:0] exp;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, t_op[i], 3'd5, t_a[i], t_b[i]);
      @(posedge clk); #1;
      exp = {1'b0, 1'b1, 3'd5, t_d[i], t_f[i]};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL alu_op%0h got=%h exp=%h", t_op[i], obs, exp); end
    end
    drive(1'b1, 4'h0, 3'd6, 8'h12, 8'h34);
    @(posedge clk); #1;
    drive(1'b0, 4'h0, 3'd0, 8'h00, 8'h00);
    exp = {1'b0, 1'b0, 3'd5, 8'h80, 3'b010};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL nop got=%h exp=%h", obs, exp); end
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    logic [15:0] exp;
    drive(1'b1, 4'hF, 3'd6, 8'h3F, 8'h7C);
    @(posedge clk); #1;
    drive(1'b1, 4'h1, 3'd3, 8'h01, 8'h02);
    for (int k = 0; k < 8; k++) begin
      exp = {1'b1, 1'b0, 3'd5, 8'h80, 3'b010};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL mul_busy%0d got=%h exp=%h", k, obs, exp); end
      @(posedge clk); #1;
    end
    exp = {1'b0, 1'b1, 3'd6, 8'h84, 3'b011};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mul_result got=%h exp=%h", obs, exp); end
    @(posedge clk); #1;
    drive(1'b0, 4'h0, 3'd0, 8'h00, 8'h00);
    exp = {1'b0, 1'b1, 3'd3, 8'h03, 3'b000};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mul_next_add got=%h exp=%h", obs, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_reset();
    logic [15:0] exp;
    drive(1'b1, 4'h1, 3'd1, 8'hFF, 8'h01);
    @(posedge clk); #1;
    drive(1'b1, 4'hF, 3'd7, 8'h03, 8'h03);
    @(posedge clk); #1;
    drive(1'b0, 4'h0, 3'd0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 16'h0000) begin bad++; $display("FAIL mulrst_state got=%h exp=%h", obs, 16'h0000); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== 16'h0000) begin bad++; $display("FAIL mulrst_quiet%0d got=%h exp=%h", k, obs, 16'h0000); end
    end
    drive(1'b1, 4'h1, 3'd2, 8'h10, 8'h20);
    @(posedge clk); #1;
    drive(1'b0, 4'h0, 3'd0, 8'h00, 8'h00);
    exp = {1'b0, 1'b1, 3'd2, 8'h30, 3'b000};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mulrst_add got=%h exp=%h", obs, exp); end
  endtask
`else
  task automatic test_mul_disabled();
    logic [15:0] exp;
    drive(1'b1, 4'h1, 3'd1, 8'hFF, 8'h01);
    @(posedge clk); #1;
    drive(1'b1, 4'hF, 3'd4, 8'h02, 8'h03);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      exp = {1'b0, 1'b0, 3'd1, 8'h00, 3'b101};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL muloff%0d got=%h exp=%h", k, obs, exp); end
    end
    drive(1'b1, 4'h1, 3'd2, 8'h10, 8'h20);
    @(posedge clk); #1;
    drive(1'b0, 4'h0, 3'd0, 8'h00, 8'h00);
    exp = {1'b0, 1'b1, 3'd2, 8'h30, 3'b000};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL muloff_add got=%h exp=%h", obs, exp); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_alu_ops();
`ifdef EXEC_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
